// File: rtl/stopwatch_pkg.sv
// Shared definitions for the MM:SS stopwatch: FSM state encoding and digit limits.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Largest legal value of a tens digit (seconds and minutes both stop at 5).
    localparam int SEC_TENS_MAX = 5;
    // Largest legal value of a ones digit.
    localparam int ONES_MAX     = 9;

endpackage

// File: rtl/modulo_n_counter.sv
// Modulo-N digit counter with synchronous clear and count enable; carry marks the N-1 -> 0 step.
// Latency: count updates one cycle after enable/clr; carry is combinational from enable and count.
// Backpressure: none; enable and clr are honoured every cycle.
module modulo_n_counter #(
    parameter int N     = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(N - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear beats enable, and the digit wraps to 0 after N-1.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (enable) begin
            if (count_q == CNT_MAX) begin
                count_d = '0;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    // Digit register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // Next stage only advances when this one is enabled and rolling over.
    assign carry = enable && (count_q == CNT_MAX);

endmodule

// File: rtl/stopwatch_controller.sv
// MM:SS stopwatch: run/pause/clear FSM, tick prescaler and a four-digit modulo cascade.
// Latency: running follows start_stop by one edge; first count appears TICK_DIV edges after start.
// Backpressure: none; start_stop/clear pulses are acted on the cycle they are sampled.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [2:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [2:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          running_q;
    logic          wrap_q;
    logic          wrap_d;

    logic          tick;
    logic          so_carry;
    logic          st_carry;
    logic          mo_carry;
    logic          mt_carry;

    // The tick fires on the RUN edge where the prescaler sits at its last value.
    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // Next state and prescaler: clear first, then start_stop; prescaler only moves in RUN.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;

        if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else if (start_stop) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
                ST_RUN:   state_d = ST_PAUSE;
                // Resuming keeps the partial prescaler count so pause time is not lost.
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // A rollover of the top digit is 59:59 -> 00:00; a same-cycle clear cancels it.
    assign wrap_d = mt_carry && !clear;

    // State, prescaler and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            running_q <= (state_d == ST_RUN);
            wrap_q    <= wrap_d;
        end
    end

    modulo_n_counter #(.N(ONES_MAX + 1), .WIDTH(4)) u_sec_ones (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .enable (tick),
        .count  (sec_ones),
        .carry  (so_carry)
    );

    modulo_n_counter #(.N(SEC_TENS_MAX + 1), .WIDTH(3)) u_sec_tens (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .enable (so_carry),
        .count  (sec_tens),
        .carry  (st_carry)
    );

    modulo_n_counter #(.N(ONES_MAX + 1), .WIDTH(4)) u_min_ones (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .enable (st_carry),
        .count  (min_ones),
        .carry  (mo_carry)
    );

    modulo_n_counter #(.N(SEC_TENS_MAX + 1), .WIDTH(3)) u_min_tens (
        .clk    (clk),
        .reset  (reset),
        .clr    (clear),
        .enable (mo_carry),
        .count  (min_tens),
        .carry  (mt_carry)
    );

    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller at TICK_DIV = 4.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_ones;
    logic [2:0] sec_tens;
    logic [3:0] min_ones;
    logic [2:0] min_tens;
    logic       running;
    logic       wrap;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_controller #(.TICK_DIV(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .sec_ones   (sec_ones),
        .sec_tens   (sec_tens),
        .min_ones   (min_ones),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_stop = 1'b1;
        step(1);
        start_stop = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare the displayed time against mm:ss written in decimal.
    task automatic chk_time(input string tag, input int mm, input int ss);
        logic [13:0] obs;
        logic [13:0] exp;
        obs = {min_tens, min_ones, sec_tens, sec_ones};
        exp = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d%0d:%0d%0d expected %02d:%02d",
                   tag, min_tens, min_ones, sec_tens, sec_ones, mm, ss);
        end
    endtask

    initial begin
        reset      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;

        // Reset state
        step(1);
        reset = 1'b1;
        chk_time("reset_digits", 0, 0);
        chk_bit("reset_running", running, 1'b0);
        chk_bit("reset_wrap", wrap, 1'b0);

        // Start: running next edge, first count at k+4, 00:10 at k+40
        pulse_start();
        chk_bit("start_running", running, 1'b1);
        chk_time("start_digits", 0, 0);
        step(3);
        chk_time("before_first_tick", 0, 0);
        step(1);
        chk_time("first_tick", 0, 1);
        step(36);
        chk_time("ten_seconds", 0, 10);

        // Pause two cycles after the tick, hold, then resume
        step(1);
        pulse_start();
        chk_bit("pause_running", running, 1'b0);
        step(20);
        chk_time("pause_hold", 0, 10);
        chk_bit("pause_hold_running", running, 1'b0);
        pulse_start();
        chk_bit("resume_running", running, 1'b1);
        chk_time("resume_digits", 0, 10);
        step(1);
        chk_time("resume_plus1", 0, 10);
        step(1);
        chk_time("resume_plus2", 0, 11);

        // Full range: 3588 more ticks reach 59:59, next tick wraps
        step(3588 * 4);
        chk_time("full_5959", 59, 59);
        chk_bit("full_no_wrap", wrap, 1'b0);
        step(3);
        chk_time("full_5959_hold", 59, 59);
        chk_bit("pre_wrap", wrap, 1'b0);
        step(1);
        chk_time("wrap_digits", 0, 0);
        chk_bit("wrap_pulse", wrap, 1'b1);
        chk_bit("wrap_running", running, 1'b1);
        step(1);
        chk_bit("wrap_one_cycle", wrap, 1'b0);

        // Clear returns to idle
        pulse_clear();
        chk_time("clear_digits", 0, 0);
        chk_bit("clear_running", running, 1'b0);

        // Clear on a tick edge discards the tick
        pulse_start();
        step(3);
        pulse_clear();
        chk_time("clear_on_tick", 0, 0);
        chk_bit("clear_on_tick_running", running, 1'b0);

        // Clear and start_stop together at 03:27: clear wins
        pulse_start();
        step(207 * 4);
        chk_time("at_0327", 3, 27);
        clear      = 1'b1;
        start_stop = 1'b1;
        step(1);
        clear      = 1'b0;
        start_stop = 1'b0;
        chk_time("clear_start_digits", 0, 0);
        chk_bit("clear_start_running", running, 1'b0);
        step(8);
        chk_time("idle_hold", 0, 0);
        chk_bit("idle_hold_running", running, 1'b0);

        // Reset mid-run at 12:34, then restart from 00:00
        pulse_start();
        step(754 * 4);
        chk_time("at_1234", 12, 34);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        chk_time("midrun_reset_digits", 0, 0);
        chk_bit("midrun_reset_running", running, 1'b0);
        chk_bit("midrun_reset_wrap", wrap, 1'b0);
        step(5);
        chk_time("post_reset_idle", 0, 0);
        pulse_start();
        chk_bit("restart_running", running, 1'b1);
        step(4);
        chk_time("restart_first_tick", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
